// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter: execute and memory requesters share the register file's single write port.
// Optional macro RF_WB_XZR_DISCARD_EN: writes to register 31 are handshaken but never reach the port.
module rf_wb_arbiter #(
   parameter int DATA_W   = 64,
   parameter int ADDR_W   = 5,
   parameter int MAX_WAIT = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ex_valid,
   input  logic [ADDR_W-1:0] ex_rd,
   input  logic [DATA_W-1:0] ex_data,
   output logic              ex_ready,
   input  logic              mem_valid,
   input  logic [ADDR_W-1:0] mem_rd,
   input  logic [DATA_W-1:0] mem_data,
   output logic              mem_ready,
   output logic [ADDR_W-1:0] rf_Rd,
   output logic [DATA_W-1:0] rf_dataWrite,
   output logic              rf_enable_registros,
   output logic              ex_starved
);

   // Handshake: a write moves when valid && ready in the same cycle; ready is combinational
   // from this cycle's valids and wait_cnt, one-hot, and never raised without valid.
   localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

   logic [3:0]        wait_cnt;
   logic              grant_ex;
   logic              grant_mem;
   logic              xfer;
   logic              write_en;
   logic [ADDR_W-1:0] sel_rd;
   logic [DATA_W-1:0] sel_data;

   // Memory wins contention until execute has been refused MAX_WAIT cycles in a row.
   always_comb begin
      grant_ex  = 1'b0;
      grant_mem = 1'b0;
      if (!reset) begin
         if (ex_valid && (!mem_valid || wait_cnt == MAX_W)) begin
            grant_ex = 1'b1;
         end else if (mem_valid) begin
            grant_mem = 1'b1;
         end
      end
   end

   assign ex_ready   = grant_ex;
   assign mem_ready  = grant_mem;
   assign ex_starved = (wait_cnt == MAX_W);
   assign xfer       = grant_ex | grant_mem;
   assign sel_rd     = grant_ex ? ex_rd   : mem_rd;
   assign sel_data   = grant_ex ? ex_data : mem_data;

`ifdef RF_WB_XZR_DISCARD_EN
   assign write_en = xfer && (sel_rd != ADDR_W'(31));
`else
   assign write_en = xfer;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt <= 4'd0;
      end else if (!ex_valid || grant_ex) begin
         wait_cnt <= 4'd0;
      end else if (wait_cnt < MAX_W) begin
         wait_cnt <= wait_cnt + 4'd1;
      end
   end

   // Registered write port: enable pulses one cycle per accepted write, address/data hold otherwise.
   always_ff @(posedge clk) begin
      if (reset) begin
         rf_enable_registros <= 1'b0;
         rf_Rd               <= '0;
         rf_dataWrite        <= '0;
      end else begin
         rf_enable_registros <= write_en;
         if (write_en) begin
            rf_Rd        <= sel_rd;
            rf_dataWrite <= sel_data;
         end
      end
   end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: readys checked mid-cycle, write port checked on the falling edge.
// Expectations follow RF_WB_XZR_DISCARD_EN when it is defined for the build.
module tb_rf_wb_arbiter;

   localparam int DATA_W = 64;
   localparam int ADDR_W = 5;

   logic              clk = 1'b0;
   logic              reset;
   logic              ex_valid, mem_valid;
   logic [ADDR_W-1:0] ex_rd, mem_rd;
   logic [DATA_W-1:0] ex_data, mem_data;
   logic              ex_ready, mem_ready;
   logic [ADDR_W-1:0] rf_Rd;
   logic [DATA_W-1:0] rf_dataWrite;
   logic              rf_enable_registros;
   logic              ex_starved;

   int pass_cnt  = 0;
   int total_cnt = 0;

   logic [ADDR_W+DATA_W-1:0] exp_q[$];
   logic [DATA_W-1:0]        rf_model[32];

   rf_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_WAIT(3)) dut (
      .clk(clk), .reset(reset),
      .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_data(ex_data), .ex_ready(ex_ready),
      .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
      .rf_Rd(rf_Rd), .rf_dataWrite(rf_dataWrite),
      .rf_enable_registros(rf_enable_registros), .ex_starved(ex_starved)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic drive(input logic ev, input logic [ADDR_W-1:0] er, input logic [DATA_W-1:0] ed,
                        input logic mv, input logic [ADDR_W-1:0] mr, input logic [DATA_W-1:0] md);
      ex_valid = ev; ex_rd = er; ex_data = ed;
      mem_valid = mv; mem_rd = mr; mem_data = md;
   endtask

   task automatic chk_ready(input string tag, input logic exp_ex, input logic exp_mem);
      #1;
      chk({tag, "_ex_ready"}, DATA_W'(ex_ready), DATA_W'(exp_ex));
      chk({tag, "_mem_ready"}, DATA_W'(mem_ready), DATA_W'(exp_mem));
   endtask

   task automatic chk_port(input string tag, input logic en, input logic [ADDR_W-1:0] rd,
                           input logic [DATA_W-1:0] data);
      chk({tag, "_en"}, DATA_W'(rf_enable_registros), DATA_W'(en));
      chk({tag, "_rd"}, DATA_W'(rf_Rd), DATA_W'(rd));
      chk({tag, "_data"}, rf_dataWrite, data);
   endtask

   // Register file stand-in, and scoreboard matching every enable pulse to an expected write.
   always @(posedge clk) begin
      if (rf_enable_registros === 1'b1) rf_model[rf_Rd] <= rf_dataWrite;
   end

   always @(negedge clk) begin
      if (rf_enable_registros === 1'b1) begin
         chk("sb_write_expected", DATA_W'(exp_q.size() != 0), DATA_W'(1));
         if (exp_q.size() != 0) chk("sb_write_value", DATA_W'({rf_Rd, rf_dataWrite}), DATA_W'(exp_q.pop_front()));
      end
   end

   logic [2:0] c_ex_r, c_mem_r, c_starve;

   initial begin
      for (int i = 0; i < 32; i++) rf_model[i] = '0;
      reset = 1'b1;
      drive(1'b1, 5'd1, 64'h11, 1'b1, 5'd2, 64'h22);

      // Reset held two cycles with both requesters valid
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk_port("reset", 1'b0, 5'd0, 64'd0);
         chk("reset_starved", DATA_W'(ex_starved), 64'd0);
         chk_ready("reset", 1'b0, 1'b0);
      end
      @(negedge clk);
      reset = 1'b0;
      drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
      chk_ready("idle", 1'b0, 1'b0);

      // Single execute write
      @(negedge clk);
      drive(1'b1, 5'd3, 64'h1234, 1'b0, 5'd0, 64'd0);
      chk_ready("single", 1'b1, 1'b0);
      exp_q.push_back({5'd3, 64'h1234});
      @(negedge clk);
      drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
      chk_port("single_n1", 1'b1, 5'd3, 64'h1234);
      chk_ready("single_idle", 1'b0, 1'b0);
      @(negedge clk);
      chk_port("single_n2", 1'b0, 5'd3, 64'h1234);

      // Contention: mem presents a new write each cycle, ex forced through on the 4th
      c_mem_r  = 3'b111;
      c_ex_r   = 3'b000;
      c_starve = 3'b000;
      for (int i = 0; i < 5; i++) begin
         logic exp_ex, exp_mem, exp_st;
         exp_ex  = (i == 3);
         exp_mem = (i != 3);
         exp_st  = (i == 3);
         drive(i != 4, 5'd6, 64'hBB, 1'b1, 5'd5, 64'hAA + 64'(i));
         #1;
         chk($sformatf("contend%0d_starved", i), DATA_W'(ex_starved), DATA_W'(exp_st));
         chk($sformatf("contend%0d_ex_ready", i), DATA_W'(ex_ready), DATA_W'(exp_ex));
         chk($sformatf("contend%0d_mem_ready", i), DATA_W'(mem_ready), DATA_W'(exp_mem));
         if (exp_ex) exp_q.push_back({5'd6, 64'hBB});
         else        exp_q.push_back({5'd5, 64'hAA + 64'(i)});
         @(negedge clk);
         if (i == 3) chk_port("contend_ex_write", 1'b1, 5'd6, 64'hBB);
      end
      drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
      chk_port("contend_last", 1'b1, 5'd5, 64'hAE);
      @(negedge clk);

      // Same destination: mem lands first, ex overwrites
      drive(1'b1, 5'd7, 64'h2, 1'b1, 5'd7, 64'h1);
      chk_ready("samerd_c0", 1'b0, 1'b1);
      exp_q.push_back({5'd7, 64'h1});
      @(negedge clk);
      drive(1'b1, 5'd7, 64'h2, 1'b0, 5'd0, 64'd0);
      chk_port("samerd_w0", 1'b1, 5'd7, 64'h1);
      chk_ready("samerd_c1", 1'b1, 1'b0);
      exp_q.push_back({5'd7, 64'h2});
      @(negedge clk);
      drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
      chk_port("samerd_w1", 1'b1, 5'd7, 64'h2);
      @(negedge clk);
      chk("samerd_reg7", rf_model[7], 64'h2);

      // Back-to-back execute writes, one per cycle
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 5'(8 + i), 64'h100 + 64'(i), 1'b0, 5'd0, 64'd0);
         chk_ready($sformatf("b2b%0d", i), 1'b1, 1'b0);
         exp_q.push_back({5'(8 + i), 64'h100 + 64'(i)});
         @(negedge clk);
         chk_port($sformatf("b2b%0d_w", i), 1'b1, 5'(8 + i), 64'h100 + 64'(i));
      end
      drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
      @(negedge clk);
      chk("b2b_gap_en", DATA_W'(rf_enable_registros), 64'd0);

      // Write to register 31
      drive(1'b1, 5'd31, 64'hFFFF, 1'b0, 5'd0, 64'd0);
      chk_ready("xzr", 1'b1, 1'b0);
`ifndef RF_WB_XZR_DISCARD_EN
      exp_q.push_back({5'd31, 64'hFFFF});
`endif
      @(negedge clk);
      drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
`ifdef RF_WB_XZR_DISCARD_EN
      chk_port("xzr_w", 1'b0, 5'd11, 64'h103);
`else
      chk_port("xzr_w", 1'b1, 5'd31, 64'hFFFF);
`endif
      @(negedge clk);

      // Reset overrides a transfer presented in the same cycle
      drive(1'b1, 5'd4, 64'h55, 1'b1, 5'd9, 64'h66);
      reset = 1'b1;
      chk_ready("rst_mid", 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
      chk_port("rst_mid_w", 1'b0, 5'd0, 64'd0);
      @(negedge clk);
      chk("sb_drained", DATA_W'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #20000;
      total_cnt++;
      $display("FAIL timeout: bench did not complete within 20000 time units");
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $fatal(1, "timeout");
   end

endmodule
